// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding one shared uart_tx.
// Issues are paced to the 10-baud frame so frames run back-to-back.
module uart_tx_arbiter #(
  parameter  int N_REQ        = 4,
  parameter  int FRAME_CYCLES = 10,
  parameter  int MAX_BURST    = 4,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               baud_clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_data_en,
  output logic [7:0]         tx_data,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  localparam int CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic [1:0] {
    GUARD,
    IDLE,
    ISSUE,
    FRAME
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic [3:0]      burst_cnt;
  logic [GW-1:0]   rr_ptr;

  logic            window;
  logic            accept;
  logic            cont;
  logic            srch_hit;
  logic [GW-1:0]   srch_idx;
  logic [GW-1:0]   idx;
  logic [GW-1:0]   winner;
  logic [7:0]      win_byte;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    srch_hit = 1'b0;
    srch_idx = '0;
    idx      = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!srch_hit && req_valid[idx]) begin
        srch_hit = 1'b1;
        srch_idx = idx;
      end
      idx = (idx == GW'(N_REQ - 1)) ? '0 : idx + GW'(1);
    end
  end

  // burst_cnt==0 means no burst in progress.
  assign cont = (burst_cnt != 4'd0)
             && (burst_cnt < 4'(MAX_BURST))
             && req_valid[grant_id];

  assign winner = cont ? grant_id : srch_idx;

  assign window = rst_n
               && ((state == IDLE)
               || ((state == FRAME)
               && (cnt == CW'(FRAME_CYCLES - 2))));

  assign accept = window && (|req_valid);
  assign busy   = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready = N_REQ'(1) << winner;
  end

  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == winner) win_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      GUARD: begin
        if (cnt == CW'(FRAME_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = FRAME;
        cnt_d   = '0;
      end
      FRAME: begin
        cnt_d = cnt + CW'(1);
        if (window) state_d = accept ? ISSUE : IDLE;
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (!rst_n) begin
      state      <= GUARD;
      cnt        <= '0;
      tx_data_en <= 1'b0;
      tx_data    <= 8'h00;
      grant_id   <= '0;
      burst_cnt  <= 4'd0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      tx_data_en <= accept;
      if (accept) begin
        tx_data  <= win_byte;
        grant_id <= winner;
        if (cont) begin
          burst_cnt <= burst_cnt + 4'd1;
        end else begin
          burst_cnt <= 4'd1;
          rr_ptr    <= (srch_idx == GW'(N_REQ - 1))
                     ? '0 : srch_idx + GW'(1);
        end
      end else if (window) begin
        burst_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised + directed bench for uart_tx_arbiter with a
// timeline-level arbiter model and a serial uart_tx line model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int FC = 10;
  localparam int MB = 4;

  logic           baud_clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_data_en;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arbiter #(
    .N_REQ(N),
    .FRAME_CYCLES(FC),
    .MAX_BURST(MB)
  ) dut (
    .baud_clk(baud_clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_data_en(tx_data_en),
    .tx_data(tx_data),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 baud_clk = ~baud_clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] pq [N][$];
  logic [N-1:0] mask;

  int cyc = 0;
  int rel_cyc = 0;
  int acc_who[$];
  int acc_t[$];
  bit known = 0;

  // model: guard cycles left, edges since last accept,
  // burst length of current owner, rr start point
  int g_left = FC;
  int since = 99;
  int m_bc = 0;
  int m_rr = 0;
  int m_gid = 0;
  bit m_en = 0;
  logic [7:0] m_txd = 8'h00;

  int line_q[$];
  bit line_trace[$];

  logic [N-1:0] last_rdy;
  logic last_en;
  logic last_busy;
  logic [7:0] last_txd;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = mask[i] && (pq[i].size() != 0);
      req_data[8*i +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
  endtask

  task automatic tick();
    int win;
    int nbc;
    int nrr;
    bit fnd;
    bit win_open;
    bit acc;
    bit lb;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] rdy_s;
    logic [N-1:0] val_s;
    logic en_s;
    logic [7:0] d_s;
    drive();
    @(negedge baud_clk);
    win_open = rst_n && (g_left == 0) && (since >= FC - 1);
    acc = win_open && (req_valid != '0);
    win = 0;
    nbc = 0;
    nrr = m_rr;
    if (acc) begin
      if (m_bc > 0 && m_bc < MB && req_valid[m_gid]) begin
        win = m_gid;
        nbc = m_bc + 1;
      end else begin
        fnd = 0;
        for (int k = 0; k < N; k++) begin
          if (!fnd && req_valid[(m_rr + k) % N]) begin
            fnd = 1;
            win = (m_rr + k) % N;
          end
        end
        nbc = 1;
        nrr = (win + 1) % N;
      end
    end
    exp_rdy = acc ? N'(1 << win) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (known) begin
      chk("tx_data_en", 32'(tx_data_en), 32'(m_en));
      chk("tx_data", 32'(tx_data), 32'(m_txd));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("busy", 32'(busy),
          32'(!(g_left == 0 && since >= FC)));
    end
    last_rdy  = req_ready;
    last_en   = tx_data_en;
    last_busy = busy;
    last_txd  = tx_data;
    rdy_s = req_ready;
    val_s = req_valid;
    en_s  = tx_data_en;
    d_s   = tx_data;
    @(posedge baud_clk);
    cyc++;
    lb = 1;
    if (line_q.size() > 0) lb = (line_q.pop_front() != 0);
    line_trace.push_back(lb);
    if (en_s === 1'b1) begin
      chk("uart_no_overlap", 32'(line_q.size()), 0);
      line_q.push_back(0);
      for (int b = 0; b < 8; b++) line_q.push_back(int'(d_s[b]));
      line_q.push_back(1);
    end
    for (int i = 0; i < N; i++) begin
      if (rdy_s[i] && val_s[i]) void'(pq[i].pop_front());
    end
    if (!rst_n) begin
      known = 1;
      rel_cyc = cyc;
      g_left = FC;
      since = 99;
      m_bc = 0;
      m_rr = 0;
      m_gid = 0;
      m_en = 0;
      m_txd = 8'h00;
    end else begin
      m_en = acc;
      if (acc) begin
        m_txd = req_data[8*win +: 8];
        m_gid = win;
        m_bc = nbc;
        m_rr = nrr;
        since = 0;
        acc_who.push_back(win);
        acc_t.push_back(cyc);
      end else begin
        if (win_open) m_bc = 0;
        if (since < 99) since++;
      end
      if (g_left > 0) g_left--;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_acc(input int target, input int bound);
    int c;
    c = 0;
    while (acc_who.size() < target && c < bound) begin
      tick();
      c++;
    end
    if (acc_who.size() < target) begin
      fails++;
      tests++;
      $display("FAIL wait_accept: got %0d accepts expected %0d",
               acc_who.size(), target);
    end
  endtask

  task automatic drain(input int bound);
    int c;
    int pend;
    c = 0;
    pend = 1;
    while (pend != 0 && c < bound) begin
      tick();
      c++;
      pend = 0;
      for (int i = 0; i < N; i++) pend += pq[i].size();
    end
    if (pend != 0) begin
      fails++;
      tests++;
      $display("FAIL drain: got %0d bytes pending expected 0", pend);
    end
    ticks(FC + 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  int exp_ord[17] = '{0, 0, 0, 0, 1, 1, 1, 1,
                      2, 2, 2, 2, 3, 3, 3, 3, 0};

  initial begin
    int n;
    int s;
    int ones;
    logic [7:0] by;
    mask = '1;
    req_valid = '0;
    req_data = '0;
    rst_n = 1'b0;
    ticks(3);
    rst_n = 1'b1;

    // lone byte after reset: GUARD then accept
    pq[0].push_back(8'h55);
    for (int i = 0; i < FC; i++) begin
      tick();
      chk("guard_ready_zero", 32'(last_rdy), 0);
    end
    tick();
    chk("first_ready", 32'(last_rdy), 32'h1);
    chk("first_acc_cycle", 32'(acc_t[$] - rel_cyc), 11);
    tick();
    chk("issue_en", 32'(last_en), 1);
    chk("issue_data", 32'(last_txd), 32'h55);
    chk("issue_busy", 32'(last_busy), 1);
    ticks(FC + 2);

    // streamed frames are contiguous on the line
    line_trace.delete();
    n = acc_t.size();
    pq[2].push_back(8'hA0);
    pq[2].push_back(8'hA1);
    pq[2].push_back(8'hA2);
    wait_acc(n + 3, 100);
    ticks(FC + 4);
    if (acc_t.size() >= n + 3) begin
      chk("stream_gap1", 32'(acc_t[n+1] - acc_t[n]), 10);
      chk("stream_gap2", 32'(acc_t[n+2] - acc_t[n+1]), 10);
    end
    s = 0;
    while (s < line_trace.size() && line_trace[s]) s++;
    chk("stream_trace_len", 32'(s + 30 <= line_trace.size()), 1);
    if (s + 30 <= line_trace.size()) begin
      for (int f = 0; f < 3; f++) begin
        chk("uart_start", 32'(line_trace[s + 10*f]), 0);
        for (int b = 0; b < 8; b++) by[b] = line_trace[s + 10*f + 1 + b];
        chk("uart_byte", 32'(by), 32'(8'hA0 + f));
        chk("uart_stop", 32'(line_trace[s + 10*f + 9]), 1);
      end
    end

    // all four requesters busy: bursts of MAX_BURST in rr order
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 5; k++) pq[i].push_back(8'(16*i + k));
    end
    n = acc_who.size();
    wait_acc(n + 17, 400);
    if (acc_who.size() >= n + 17) begin
      for (int k = 0; k < 17; k++) begin
        chk("rr_order", 32'(acc_who[n+k]), 32'(exp_ord[k]));
      end
    end
    drain(400);

    // lone requester is never throttled
    n = acc_who.size();
    for (int k = 0; k < 6; k++) pq[3].push_back(8'(8'hC0 + k));
    wait_acc(n + 6, 200);
    if (acc_who.size() >= n + 6) begin
      for (int k = 1; k < 6; k++) begin
        chk("lone_gap", 32'(acc_t[n+k] - acc_t[n+k-1]), 10);
        chk("lone_who", 32'(acc_who[n+k]), 3);
      end
    end
    drain(100);

    // requester 1 drops before the window, 0 arrives in it
    n = acc_who.size();
    pq[3].push_back(8'h3C);
    wait_acc(n + 1, 50);
    ticks(3);
    pq[1].push_back(8'hEE);
    ticks(3);
    mask[1] = 1'b0;
    ticks(3);
    pq[0].push_back(8'h0F);
    tick();
    chk("drop_acc_count", 32'(acc_who.size()), 32'(n + 2));
    chk("drop_winner", 32'(acc_who[$]), 0);
    ticks(FC + 2);
    ones = 0;
    for (int k = n; k < acc_who.size(); k++) begin
      if (acc_who[k] == 1) ones++;
    end
    chk("drop_no_req1", 32'(ones), 0);
    pq[1].delete();
    mask = '1;

    // reset in the middle of a frame
    n = acc_who.size();
    pq[2].push_back(8'h81);
    wait_acc(n + 1, 50);
    ticks(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pq[0].push_back(8'h42);
    for (int i = 0; i < FC; i++) begin
      tick();
      chk("rst_guard_en", 32'(last_en), 0);
      chk("rst_guard_busy", 32'(last_busy), 1);
    end
    chk("rst_line_drained", 32'(line_q.size()), 0);
    chk("rst_line_idle", 32'(line_trace[$]), 1);
    wait_acc(n + 2, 20);
    chk("rst_acc_cycle", 32'(acc_t[$] - rel_cyc), 11);
    drain(50);

    // random traffic with occasional valid drops
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, N - 1);
        if (pq[s].size() < 4) pq[s].push_back(8'($urandom));
      end
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
      tick();
    end
    mask = '1;
    drain(600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx between N_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes and drives the uart_tx data_en/data_in pins.
- Paces issues to the transmitter's fixed 10-baud-cycle frame, so back-to-back frames leave no idle gap and no byte is ever dropped.
- Sits between the producers and uart_tx. Both run on baud_clk.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_CYCLES, 10, baud cycles per frame: start + 8 data + stop.
- MAX_BURST, 4, max consecutive bytes one requester may send while others are waiting (1..15).

Ports:
- baud_clk  input  1  baud-rate clock; all logic is on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  N_REQ  requester i has a byte pending.
- req_data  input  8*N_REQ  byte of requester i in bits [8i+7:8i].
- req_ready  output  N_REQ  combinational one-hot; the byte transfers on the edge where valid&ready.
- tx_data_en  output  1  registered; drives uart_tx data_en.
- tx_data  output  8  registered; drives uart_tx data_in.
- grant_id  output  max(1,clog2(N_REQ))  registered; index of the last accepted requester.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at an edge) sets:
  - state=GUARD, cnt=0, tx_data_en=0, tx_data=0, grant_id=0, burst_cnt=0, rr_ptr=0.
  - req_ready=0 throughout reset.
  - Reset mid-frame abandons the current frame.
- States:
  - GUARD: waits FRAME_CYCLES cycles after reset release so a uart_tx caught mid-frame drains to IDLE. req_ready=0. When cnt==FRAME_CYCLES-1, go to IDLE and clear cnt.
  - IDLE: an accept window (see below). No valid request: stay in IDLE.
  - ISSUE: lasts exactly 1 cycle with tx_data_en=1; tx_data holds the accepted byte. Next state FRAME with cnt=0.
  - FRAME: tx_data_en=0; tx_data is held unchanged. cnt increments each cycle. When cnt==FRAME_CYCLES-2, the cycle is an accept window: on accept go to ISSUE, otherwise go to IDLE.
- Accept window behaviour:
  - The arbiter drives exactly one req_ready bit high if any req_valid is high.
  - At that edge it registers tx_data=req_data[winner], grant_id=winner, and goes to ISSUE.
- Timing:
  - Accept to tx_data_en high: 1 cycle.
  - Minimum spacing between successive tx_data_en pulses: FRAME_CYCLES (10). Each subsequent pulse therefore lands in uart_tx STOP, and frames run back-to-back.
  - tx_data is stable from the ISSUE cycle until the next accept, covering uart_tx's START latch cycle.
- Arbitration:
  - Burst continuation: if the previous winner p is still valid and burst_cnt < MAX_BURST, p wins and burst_cnt increments.
  - Otherwise the first valid index is searched starting from rr_ptr, wrapping at N_REQ-1 to 0. That winner gets burst_cnt=1, and rr_ptr=(winner+1) mod N_REQ.
  - If p is the only valid requester, p wins and burst_cnt restarts at 1, so a lone requester is never throttled.
  - Going through IDLE (no valid request) resets burst_cnt to 0.
- Handshake rules:
  - req_valid may drop without a transfer; the arbiter never latches a byte unless it is accepted.
  - A requester must hold req_data stable while valid is high and not yet accepted.
  - Simultaneous valids are resolved by the search above in the same cycle.
- Width rules:
  - cnt is wide enough for FRAME_CYCLES-1.
  - burst_cnt is 4 bits and saturates at MAX_BURST.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0x55 held → req_ready stays 0 for 10 cycles (GUARD). Then req_ready[0]=1 for one cycle, tx_data_en pulses 1 cycle later with tx_data=0x55, busy=1.
- Requester 2 streams 0xA0,0xA1,0xA2 with valid held → tx_data_en pulses exactly 10 cycles apart. A uart_tx model emits 30 contiguous bits with no idle high between frames, and decodes 0xA0,0xA1,0xA2.
- All four valid continuously, MAX_BURST=4 → grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…; grant_id matches the order and no requester starves.
- Only requester 3 valid for 6 bytes → 6 accepts spaced 10 cycles apart; no throttling gap after the 4th byte.
- Requester 1 valid, dropped before the accept window; requester 0 raises valid in the accept cycle → requester 0 wins; no byte from requester 1 is sent.
- rst_n=0 asserted in cycle 5 of a frame → tx_data_en=0, busy=1 (GUARD) for 10 cycles, then normal accept. The uart_tx model returns to IDLE with no spurious start bit.
